// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer.
// Latency: ack at cycle N gives instr_valid_o at N+1; accept at M gives a new imem_req_o at M+1.
// Backpressure: instr_valid_o is held with instr_o/pc_o stable until instr_ready_i; no fetch is issued meanwhile.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   imem_req_o/addr_o/ack_i/data_i     req/ack fetch interface to instruction memory
//   instr_valid_o/ready_i, instr_o     valid/ready handoff of the fetched word to decode
//   pc_o, pc_plus4_o                   PC of the presented instruction and its successor
//   branch_*/jump_*/jr_*               redirect controls, sampled when decode accepts
//   err_o                              sticky misaligned jump-register error
//   retire_cnt_o                       count of accepted instructions (wraps)
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   input  logic        branch_i,
   input  logic [31:0] branch_off_i,
   input  logic        jump_i,
   input  logic [25:0] jump_idx_i,
   input  logic        jr_i,
   input  logic [31:0] jr_target_i,
   output logic        err_o,
   output logic [31:0] retire_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_VALID,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] pc_plus4;

   // The branch offset is a word offset; its top two bits shift out.
   logic        unused_off_bits;
   assign unused_off_bits = ^branch_off_i[31:30];

   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         cnt_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_ack_i) begin
               instr_d = imem_data_i;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (instr_ready_i) begin
               cnt_d   = cnt_q + 32'd1;
               state_d = S_REQ;
               if (jr_i) begin
                  // A misaligned register target still retires the JR but
                  // freezes the sequencer; pc stays on the offending JR.
                  if (jr_target_i[1:0] != 2'b00) begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end else begin
                     pc_d = jr_target_i;
                  end
               end else if (jump_i) begin
                  pc_d = {pc_plus4[31:28], jump_idx_i, 2'b00};
               end else if (branch_i) begin
                  pc_d = pc_plus4 + {branch_off_i[29:0], 2'b00};
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         S_ERR: state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req_o    = (state_q == S_REQ);
   assign imem_addr_o   = pc_q;
   assign instr_valid_o = (state_q == S_VALID);
   assign instr_o       = instr_q;
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_plus4;
   assign err_o         = err_q;
   assign retire_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        branch = 1'b0;
   logic [31:0] branch_off = 32'h0;
   logic        jump = 1'b0;
   logic [25:0] jump_idx = 26'h0;
   logic        jr = 1'b0;
   logic [31:0] jr_target = 32'h0;
   logic        err;
   logic [31:0] retire_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pc_fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_ack_i   (imem_ack),
      .imem_data_i  (imem_data),
      .instr_valid_o(instr_valid),
      .instr_ready_i(instr_ready),
      .instr_o      (instr),
      .pc_o         (pc),
      .pc_plus4_o   (pc_plus4),
      .branch_i     (branch),
      .branch_off_i (branch_off),
      .jump_i       (jump),
      .jump_idx_i   (jump_idx),
      .jr_i         (jr),
      .jr_target_i  (jr_target),
      .err_o        (err),
      .retire_cnt_o (retire_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      imem_ack = 1'b0;
      instr_ready = 1'b0;
      {jr, jump, branch} = 3'b000;
      tick;
      tick;
      rst = 1'b0;
   endtask

   // Waits (bounded) for a fetch request, then acks it for one cycle.
   task automatic serve_fetch(input logic [31:0] word, output logic [31:0] addr);
      int n = 0;
      addr = 32'hDEAD_DEAD;
      while (!imem_req && n < 20) begin
         tick;
         n++;
      end
      if (!imem_req) begin
         tests++;
         fails++;
         $display("FAIL fetch_timeout: req=%0b after %0d cycles, required 1", imem_req, n);
      end else begin
         addr = imem_addr;
         imem_ack = 1'b1;
         imem_data = word;
         tick;
         imem_ack = 1'b0;
      end
   endtask

   // Waits (bounded) for valid, then accepts for one cycle with given redirects.
   task automatic accept(input logic j_r, input logic [31:0] tgt, input logic j_p,
                         input logic [25:0] idx, input logic b_r, input logic [31:0] off);
      int n = 0;
      while (!instr_valid && n < 20) begin
         tick;
         n++;
      end
      if (!instr_valid) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: valid=%0b after %0d cycles, required 1", instr_valid, n);
      end else begin
         instr_ready = 1'b1;
         jr = j_r; jr_target = tgt;
         jump = j_p; jump_idx = idx;
         branch = b_r; branch_off = off;
         tick;
         instr_ready = 1'b0;
         {jr, jump, branch} = 3'b000;
      end
   endtask

   task automatic test_reset;
      do_reset;
      rst = 1'b1;
      tick;
      tests++;
      if ({imem_req, instr_valid, err} !== 3'b000 || instr !== 32'h0 ||
          pc !== 32'h100 || retire_cnt !== 32'h0 || pc_plus4 !== 32'h104) begin
         fails++;
         $display("FAIL reset_state: req=%0b valid=%0b err=%0b instr=%h pc=%h cnt=%0d p4=%h, required 0 0 0 0 100 0 104",
                  imem_req, instr_valid, err, instr, pc, retire_cnt, pc_plus4);
      end
      rst = 1'b0;
      tick;
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         fails++;
         $display("FAIL idle_to_req: req=%0b addr=%h, required 1 100", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential;
      logic [31:0] a;
      do_reset;
      instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         serve_fetch(32'hA000_0000 + i, a);
         tests++;
         if (a !== 32'h100 + 4 * i) begin
            fails++;
            $display("FAIL seq_addr%0d: addr=%h, required %h", i, a, 32'h100 + 4 * i);
         end
         tests++;
         if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 + i) begin
            fails++;
            $display("FAIL seq_valid%0d: valid=%0b instr=%h, required 1 %h", i, instr_valid, instr, 32'hA000_0000 + i);
         end
         tick;
         tests++;
         if (retire_cnt !== i + 1) begin
            fails++;
            $display("FAIL seq_cnt%0d: cnt=%0d, required %0d", i, retire_cnt, i + 1);
         end
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_jump;
      logic [31:0] a;
      do_reset;
      serve_fetch(32'h1, a);
      accept(1'b1, 32'h0040_0010, 1'b0, 26'h0, 1'b0, 32'h0);
      serve_fetch(32'h2, a);
      accept(1'b0, 32'h0, 1'b1, 26'h0000123, 1'b0, 32'h0);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_048C) begin
         fails++;
         $display("FAIL jump_low: req=%0b addr=%h, required 1 0000048c", imem_req, imem_addr);
      end
      serve_fetch(32'h3, a);
      accept(1'b1, 32'hF000_0000, 1'b0, 26'h0, 1'b0, 32'h0);
      serve_fetch(32'h4, a);
      accept(1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0);
      tests++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         fails++;
         $display("FAIL jump_high: addr=%h, required fffffffc", imem_addr);
      end
      serve_fetch(32'h5, a);
      tests++;
      if (pc_plus4 !== 32'h0) begin
         fails++;
         $display("FAIL pc_plus4_wrap: pc_plus4=%h, required 00000000", pc_plus4);
      end
      accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      tests++;
      if (imem_addr !== 32'h0) begin
         fails++;
         $display("FAIL seq_wrap: addr=%h, required 00000000", imem_addr);
      end
   endtask

   task automatic test_branch;
      logic [31:0] a;
      do_reset;
      serve_fetch(32'h1, a);
      accept(1'b1, 32'h200, 1'b0, 26'h0, 1'b0, 32'h0);
      serve_fetch(32'h2, a);
      accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE);
      tests++;
      if (imem_addr !== 32'h1FC) begin
         fails++;
         $display("FAIL branch_back: addr=%h, required 000001fc", imem_addr);
      end
      serve_fetch(32'h3, a);
      accept(1'b1, 32'h200, 1'b0, 26'h0, 1'b0, 32'h0);
      serve_fetch(32'h4, a);
      accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h3);
      tests++;
      if (imem_addr !== 32'h210) begin
         fails++;
         $display("FAIL branch_fwd: addr=%h, required 00000210", imem_addr);
      end
   endtask

   task automatic test_jr_priority_err;
      logic [31:0] a;
      logic        saw_req;
      do_reset;
      serve_fetch(32'h1, a);
      accept(1'b1, 32'h8000, 1'b1, 26'h5, 1'b1, 32'h10);
      serve_fetch(32'h2, a);
      tests++;
      if (a !== 32'h8000) begin
         fails++;
         $display("FAIL jr_priority: addr=%h, required 00008000", a);
      end
      accept(1'b1, 32'h8002, 1'b0, 26'h0, 1'b0, 32'h0);
      tests++;
      if (err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          retire_cnt !== 32'd2 || pc !== 32'h8000) begin
         fails++;
         $display("FAIL jr_misalign: err=%0b req=%0b valid=%0b cnt=%0d pc=%h, required 1 0 0 2 00008000",
                  err, imem_req, instr_valid, retire_cnt, pc);
      end
      saw_req = 1'b0;
      instr_ready = 1'b1;
      imem_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (imem_req || instr_valid || !err) saw_req = 1'b1;
      end
      instr_ready = 1'b0;
      imem_ack = 1'b0;
      tests++;
      if (saw_req !== 1'b0 || retire_cnt !== 32'd2) begin
         fails++;
         $display("FAIL err_sticky: left_err=%0b cnt=%0d, required 0 2", saw_req, retire_cnt);
      end
      do_reset;
      tests++;
      if (err !== 1'b0 || pc !== 32'h100) begin
         fails++;
         $display("FAIL err_clear: err=%0b pc=%h, required 0 00000100", err, pc);
      end
   endtask

   task automatic test_stall;
      logic [31:0] a;
      do_reset;
      serve_fetch(32'hCAFE_0001, a);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            imem_ack = 1'b1;
            imem_data = 32'hBAD0_BAD0;
         end
         tick;
         imem_ack = 1'b0;
         tests++;
         if (instr !== 32'hCAFE_0001 || pc !== 32'h100 || imem_req !== 1'b0 ||
             instr_valid !== 1'b1 || retire_cnt !== 32'd0) begin
            fails++;
            $display("FAIL stall%0d: instr=%h pc=%h req=%0b valid=%0b cnt=%0d, required cafe0001 00000100 0 1 0",
                     i, instr, pc, imem_req, instr_valid, retire_cnt);
         end
      end
      accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      tests++;
      if (retire_cnt !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
         fails++;
         $display("FAIL stall_release: cnt=%0d req=%0b addr=%h, required 1 1 00000104", retire_cnt, imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_in_req;
      logic [31:0] a;
      do_reset;
      serve_fetch(32'h1234_5678, a);
      accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
         fails++;
         $display("FAIL pre_reset_req: req=%0b addr=%h, required 1 00000104", imem_req, imem_addr);
      end
      imem_ack = 1'b1;
      imem_data = 32'h5555_AAAA;
      rst = 1'b1;
      tick;
      tests++;
      if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
          pc !== 32'h100 || retire_cnt !== 32'h0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_in_req: instr=%h valid=%0b req=%0b pc=%h cnt=%0d err=%0b, required 0 0 0 00000100 0 0",
                  instr, instr_valid, imem_req, pc, retire_cnt, err);
      end
      rst = 1'b0;
      tick;
      imem_ack = 1'b0;
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL restart_fetch: req=%0b addr=%h valid=%0b, required 1 00000100 0",
                  imem_req, imem_addr, instr_valid);
      end
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_jump;
      test_branch;
      test_jr_priority_err;
      test_stall;
      test_reset_in_req;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
